// File: rtl/sram2axi4_master_if.sv
// AXI4 interface bundle shared by the SRAM-style bridge and its slaves.
// Widths come from the global AXI4_* macros, defaulted here when not set by the build.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

interface axi4_if;
  logic [`AXI4_ID_WIDTH-1:0]     awid;
  logic [`AXI4_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic                          awlock;
  logic [3:0]                    awcache;
  logic [2:0]                    awprot;
  logic [3:0]                    awqos;
  logic [3:0]                    awregion;
  logic [`AXI4_USER_WIDTH-1:0]   awuser;
  logic                          awvalid;
  logic                          awready;

  logic [`AXI4_DATA_WIDTH-1:0]   wdata;
  logic [`AXI4_DATA_WIDTH/8-1:0] wstrb;
  logic                          wlast;
  logic [`AXI4_USER_WIDTH-1:0]   wuser;
  logic                          wvalid;
  logic                          wready;

  logic [`AXI4_ID_WIDTH-1:0]     bid;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;

  logic [`AXI4_ID_WIDTH-1:0]     arid;
  logic [`AXI4_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arlock;
  logic [3:0]                    arcache;
  logic [2:0]                    arprot;
  logic [3:0]                    arqos;
  logic [3:0]                    arregion;
  logic [`AXI4_USER_WIDTH-1:0]   aruser;
  logic                          arvalid;
  logic                          arready;

  logic [`AXI4_ID_WIDTH-1:0]     rid;
  logic [`AXI4_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/sram2axi4_master.sv
// Native en/wen/bm/addr/dat request port to AXI4 master bridge.
// Every accepted request becomes one single-beat AXI4 transaction; one outstanding at a time.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

module sram2axi4_master #(
  parameter int                           REQ_ADDR_WIDTH = 11,
  parameter logic [`AXI4_ADDR_WIDTH-1:0]  AXI_BASE_ADDR  = 32'h0F00_0000,
  parameter logic [`AXI4_ID_WIDTH-1:0]    AXI_ID         = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_wen_i,
  input  logic [REQ_ADDR_WIDTH-1:0]       req_addr_i,
  input  logic [`AXI4_DATA_WIDTH/8-1:0]   req_bm_i,
  input  logic [`AXI4_DATA_WIDTH-1:0]     req_dat_i,
  output logic                            rsp_valid_o,
  output logic [`AXI4_DATA_WIDTH-1:0]     rsp_dat_o,
  output logic                            rsp_err_o,
  axi4_if.master                          axi4
);

  localparam int AW     = `AXI4_ADDR_WIDTH;
  localparam int DW     = `AXI4_DATA_WIDTH;
  localparam int SW     = DW / 8;
  localparam int SIZE_L = $clog2(SW);
  localparam logic [2:0] AXSIZE = 3'(SIZE_L);
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SW-1:0]   bm_q, bm_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;

  logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = awvalid_q & axi4.awready;
  assign w_hs  = wvalid_q  & axi4.wready;
  assign b_hs  = bready_q  & axi4.bvalid;
  assign ar_hs = arvalid_q & axi4.arready;
  assign r_hs  = rready_q  & axi4.rvalid;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    bm_d        = bm_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_dat_d   = rsp_dat_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          // Word index scaled to a byte address; wraps modulo the AXI address space.
          addr_d = AXI_BASE_ADDR + (AW'(req_addr_i) << SIZE_L);
          dat_d  = req_dat_i;
          bm_d   = req_bm_i;
          if (req_wen_i) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d   = WR_RESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (axi4.bresp != RESP_OKAY);
        end
      end

      RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = axi4.rdata;
          // A single-beat read must be the last beat; anything else is a protocol error.
          rsp_err_d   = (axi4.rresp != RESP_OKAY) | ~axi4.rlast;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      dat_q       <= '0;
      bm_q        <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      bm_q        <= bm_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;

  assign axi4.awid     = AXI_ID;
  assign axi4.awaddr   = addr_q;
  assign axi4.awlen    = 8'd0;
  assign axi4.awsize   = AXSIZE;
  assign axi4.awburst  = BURST_INCR;
  assign axi4.awlock   = 1'b0;
  assign axi4.awcache  = 4'd0;
  assign axi4.awprot   = 3'd0;
  assign axi4.awqos    = 4'd0;
  assign axi4.awregion = 4'd0;
  assign axi4.awuser   = '0;
  assign axi4.awvalid  = awvalid_q;

  assign axi4.wdata    = dat_q;
  assign axi4.wstrb    = bm_q;
  assign axi4.wlast    = 1'b1;
  assign axi4.wuser    = '0;
  assign axi4.wvalid   = wvalid_q;

  assign axi4.bready   = bready_q;

  assign axi4.arid     = AXI_ID;
  assign axi4.araddr   = addr_q;
  assign axi4.arlen    = 8'd0;
  assign axi4.arsize   = AXSIZE;
  assign axi4.arburst  = BURST_INCR;
  assign axi4.arlock   = 1'b0;
  assign axi4.arcache  = 4'd0;
  assign axi4.arprot   = 3'd0;
  assign axi4.arqos    = 4'd0;
  assign axi4.arregion = 4'd0;
  assign axi4.aruser   = '0;
  assign axi4.arvalid  = arvalid_q;

  assign axi4.rready   = rready_q;

endmodule

// File: tb/tb_sram2axi4_master.sv
// Scoreboard bench for sram2axi4_master: directed requests push expected AXI beats and
// responses into queues; handshake and response monitors pop and compare.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

module tb_sram2axi4_master;
  localparam int AW = `AXI4_ADDR_WIDTH;
  localparam int DW = `AXI4_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = `AXI4_ID_WIDTH;
  localparam logic [IW-1:0] TB_ID = 4'h3;
  localparam logic [AW-1:0] BASE  = 32'h0F00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          req_valid, req_ready, req_wen;
  logic [10:0]   req_addr;
  logic [SW-1:0] req_bm;
  logic [DW-1:0] req_dat;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_dat;

  logic          w_req_valid, w_req_ready, w_req_wen;
  logic [10:0]   w_req_addr;
  logic [SW-1:0] w_req_bm;
  logic [DW-1:0] w_req_dat;
  logic          w_rsp_valid, w_rsp_err;
  logic [DW-1:0] w_rsp_dat;

  axi4_if axi();
  axi4_if axw();

  sram2axi4_master #(.REQ_ADDR_WIDTH(11), .AXI_BASE_ADDR(32'h0F00_0000), .AXI_ID(TB_ID)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_bm_i(req_bm), .req_dat_i(req_dat),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .axi4(axi)
  );

  sram2axi4_master #(.REQ_ADDR_WIDTH(11), .AXI_BASE_ADDR(32'hFFFF_FFF0), .AXI_ID(4'h0)) dut_wrap (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(w_req_valid), .req_ready_o(w_req_ready), .req_wen_i(w_req_wen),
    .req_addr_i(w_req_addr), .req_bm_i(w_req_bm), .req_dat_i(w_req_dat),
    .rsp_valid_o(w_rsp_valid), .rsp_dat_o(w_rsp_dat), .rsp_err_o(w_rsp_err),
    .axi4(axw)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=beat_present required=none_expected", name);
  endfunction

  typedef struct {
    logic          err;
    logic [DW-1:0] dat;
    int            cyc;
  } rsp_t;

  logic [AW-1:0]    exp_aw_q[$];
  logic [DW+SW-1:0] exp_w_q[$];
  logic [AW-1:0]    exp_ar_q[$];
  rsp_t             exp_rsp_q[$];
  logic [DW-1:0]    last_rd = '0;

  // slave configuration and state
  int            aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
  logic [1:0]    s_bresp = 2'b00, s_rresp = 2'b00;
  logic          s_rlast = 1'b1;
  logic [DW-1:0] mem [0:63];
  bit            aw_got, w_got, ar_got, b_act, r_act;
  logic [AW-1:0] aw_a, ar_a, s_off;
  logic [DW-1:0] w_d;
  logic [SW-1:0] w_s;
  int            aw_c, w_c, ar_c, b_c, r_c;
  bit            pend_aw, pend_w, pend_ar;
  logic [AW-1:0] hold_aw, hold_ar;
  logic [DW-1:0] hold_w;
  int            wrap_aw_cnt = 0;

  // handshake monitor: stable-until-ready checks, then pop expected beats
  always @(posedge clk) begin
    logic [AW-1:0]    ea;
    logic [DW+SW-1:0] ew;
    if (pend_aw) check("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, hold_aw});
    if (pend_w)  check("w_hold",  {axi.wvalid, axi.wdata}, {1'b1, hold_w});
    if (pend_ar) check("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, hold_ar});
    pend_aw = !rst_i && axi.awvalid && !axi.awready;
    pend_w  = !rst_i && axi.wvalid && !axi.wready;
    pend_ar = !rst_i && axi.arvalid && !axi.arready;
    hold_aw = axi.awaddr;
    hold_w  = axi.wdata;
    hold_ar = axi.araddr;
    if (rst_i) begin
      aw_got = 0; w_got = 0; ar_got = 0; b_act = 0; r_act = 0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        if (exp_aw_q.size() == 0) unexpected("aw_beat");
        else begin
          ea = exp_aw_q.pop_front();
          check("awaddr", axi.awaddr, ea);
        end
        check("aw_fields", {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.awlock,
                            axi.awcache, axi.awprot, axi.awqos, axi.awregion, axi.awuser},
              {TB_ID, 8'h00, 3'd2, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 1'b0});
        aw_got = 1; aw_a = axi.awaddr;
      end
      if (axi.wvalid && axi.wready) begin
        if (exp_w_q.size() == 0) unexpected("w_beat");
        else begin
          ew = exp_w_q.pop_front();
          check("wdata", axi.wdata, ew[DW+SW-1:SW]);
          check("wstrb", axi.wstrb, ew[SW-1:0]);
        end
        check("wlast", axi.wlast, 1'b1);
        w_got = 1; w_d = axi.wdata; w_s = axi.wstrb;
      end
      if (axi.arvalid && axi.arready) begin
        if (exp_ar_q.size() == 0) unexpected("ar_beat");
        else begin
          ea = exp_ar_q.pop_front();
          check("araddr", axi.araddr, ea);
        end
        check("ar_fields", {axi.arid, axi.arlen, axi.arsize, axi.arburst},
              {TB_ID, 8'h00, 3'd2, 2'b01});
        ar_got = 1; ar_a = axi.araddr;
      end
      if (axi.bvalid && axi.bready) b_act = 0;
      if (axi.rvalid && axi.rready) r_act = 0;
    end
    if (axw.awvalid && axw.awready) begin
      wrap_aw_cnt++;
      check("wrap_awaddr", axw.awaddr, 32'h0000_0010);
    end
  end

  // slave responder, driven away from the active edge
  always @(negedge clk) begin
    if (rst_i) begin
      axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
      aw_c = 0; w_c = 0; ar_c = 0;
    end else begin
      if (axi.awvalid) begin
        axi.awready = (aw_c >= aw_dly);
        if (aw_c < aw_dly) aw_c++;
      end else begin
        axi.awready = 0; aw_c = 0;
      end
      if (axi.wvalid) begin
        axi.wready = (w_c >= w_dly);
        if (w_c < w_dly) w_c++;
      end else begin
        axi.wready = 0; w_c = 0;
      end
      if (axi.arvalid) begin
        axi.arready = (ar_c >= ar_dly);
        if (ar_c < ar_dly) ar_c++;
      end else begin
        axi.arready = 0; ar_c = 0;
      end
      if (aw_got && w_got && !b_act) begin
        s_off = aw_a - BASE;
        for (int i = 0; i < SW; i++)
          if (w_s[i]) mem[s_off[7:2]][8*i +: 8] = w_d[8*i +: 8];
        aw_got = 0; w_got = 0; b_act = 1; b_c = 0;
      end
      if (b_act) begin
        axi.bvalid = (b_c >= b_dly);
        if (b_c < b_dly) b_c++;
        axi.bresp = s_bresp;
      end else axi.bvalid = 0;
      if (ar_got && !r_act) begin
        s_off = ar_a - BASE;
        axi.rdata = mem[s_off[7:2]];
        ar_got = 0; r_act = 1; r_c = 0;
      end
      if (r_act) begin
        axi.rvalid = (r_c >= r_dly);
        if (r_c < r_dly) r_c++;
        axi.rresp = s_rresp;
        axi.rlast = s_rlast;
      end else axi.rvalid = 0;
    end
    axw.bvalid = axw.bready;
  end

  // response scoreboard
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid) begin
      if (exp_rsp_q.size() == 0) unexpected("rsp_pulse");
      else begin
        e = exp_rsp_q.pop_front();
        check("rsp_err", rsp_err, e.err);
        check("rsp_dat", rsp_dat, e.dat);
        if (e.cyc >= 0) check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // must be entered at a negedge; returns at the negedge after acceptance
  task automatic issue(input bit wen, input logic [10:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] bm, input bit want_rsp, input bit e_err,
                       input logic [DW-1:0] e_dat, input int lat, output int acc);
    rsp_t e;
    bit   ok = 0;
    req_valid = 1; req_wen = wen; req_addr = a; req_dat = d; req_bm = bm;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (req_ready) begin
        acc = cyc + 1;
        ok = 1;
        break;
      end
    end
    if (ok) begin
      if (wen) begin
        exp_aw_q.push_back(BASE + {a, 2'b00});
        exp_w_q.push_back({d, bm});
        e.dat = last_rd;
      end else begin
        exp_ar_q.push_back(BASE + {a, 2'b00});
        e.dat = e_dat;
        last_rd = e_dat;
      end
      e.err = e_err;
      e.cyc = (lat >= 0) ? acc + lat : -1;
      if (want_rsp) exp_rsp_q.push_back(e);
    end else begin
      checks++; failures++;
      $display("FAIL req_accept actual=timeout required=accepted");
    end
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_rsp_q.size() != 0; i++) @(negedge clk);
    if (exp_rsp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain actual=%0d_pending required=0", exp_rsp_q.size());
      exp_rsp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, dummy;
    bit seen;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst_i = 1; req_valid = 0; req_wen = 0; req_addr = '0; req_bm = '0; req_dat = '0;
    w_req_valid = 0; w_req_wen = 0; w_req_addr = '0; w_req_bm = '0; w_req_dat = '0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
    axi.bid = TB_ID; axi.rid = TB_ID; axi.bresp = 0; axi.rresp = 0; axi.rlast = 1; axi.rdata = '0;
    axw.awready = 1; axw.wready = 1; axw.arready = 1; axw.bvalid = 0; axw.rvalid = 0;
    axw.bid = '0; axw.rid = '0; axw.bresp = 0; axw.rresp = 0; axw.rlast = 1; axw.rdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {req_ready, rsp_valid, rsp_err, axi.awvalid, axi.wvalid, axi.bready,
                         axi.arvalid, axi.rready}, 8'b1000_0000);
    check("reset_rsp_dat", rsp_dat, 32'h0);
    rst_i = 0;
    @(negedge clk);

    // write then read, zero-wait
    issue(1, 11'd5, 32'hDEADBEEF, 4'hF, 1, 0, '0, 2, dummy);
    issue(0, 11'd5, '0, '0, 1, 0, 32'hDEADBEEF, 2, dummy);
    // partial write
    issue(1, 11'd7, 32'h11223344, 4'hF, 1, 0, '0, 2, dummy);
    issue(1, 11'd7, 32'hAABBCCDD, 4'h5, 1, 0, '0, 2, dummy);
    issue(0, 11'd7, '0, '0, 1, 0, 32'h11BB33DD, 2, dummy);
    drain();

    // skewed AW/W handshakes
    aw_dly = 3; w_dly = 0;
    issue(1, 11'd10, 32'hA5A5_0010, 4'hF, 1, 0, '0, 5, dummy);
    drain();
    aw_dly = 0; w_dly = 3;
    issue(1, 11'd11, 32'hA5A5_0011, 4'hF, 1, 0, '0, 5, dummy);
    drain();
    aw_dly = 2; w_dly = 2;
    issue(1, 11'd12, 32'hA5A5_0012, 4'hF, 1, 0, '0, 4, dummy);
    drain();
    aw_dly = 0; w_dly = 0;
    issue(0, 11'd10, '0, '0, 1, 0, 32'hA5A5_0010, 2, dummy);
    issue(0, 11'd11, '0, '0, 1, 0, 32'hA5A5_0011, 2, dummy);
    issue(0, 11'd12, '0, '0, 1, 0, 32'hA5A5_0012, 2, dummy);
    drain();

    // error responses
    s_bresp = 2'b10;
    issue(1, 11'd20, 32'h0BAD_0020, 4'hF, 1, 1, '0, 2, dummy);
    drain();
    s_bresp = 2'b00; s_rlast = 0;
    issue(0, 11'd20, '0, '0, 1, 1, 32'h0BAD_0020, 2, dummy);
    drain();
    s_rlast = 1; s_rresp = 2'b11;
    issue(0, 11'd5, '0, '0, 1, 1, 32'hDEADBEEF, 2, dummy);
    drain();
    s_rresp = 2'b00;

    // stalled read with request held; next request taken in the rsp cycle
    ar_dly = 4; r_dly = 4;
    issue(0, 11'd7, '0, '0, 1, 0, 32'h11BB33DD, 10, a1);
    issue(1, 11'd13, 32'h1313_1313, 4'h3, 1, 0, '0, 2, a2);
    check("accept_in_rsp_cycle", a2, a1 + 11);
    drain();
    ar_dly = 0; r_dly = 0;

    // reset while waiting for B
    b_dly = 6;
    issue(1, 11'd30, 32'h3030_3030, 4'hF, 0, 0, '0, -1, dummy);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (axi.bready) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("reached_wr_resp", seen, 1'b1);
    rst_i = 1;
    @(negedge clk);
    check("rst_mid_ctrl", {req_ready, rsp_valid, axi.awvalid, axi.wvalid, axi.bready,
                           axi.arvalid, axi.rready}, 7'b100_0000);
    check("rst_mid_rsp_dat", rsp_dat, 32'h0);
    rst_i = 0;
    last_rd = '0;
    b_dly = 0;
    repeat (10) @(negedge clk);
    issue(0, 11'd5, '0, '0, 1, 0, 32'hDEADBEEF, 2, dummy);
    drain();

    // address wrap on the second instance
    w_req_valid = 1; w_req_wen = 1; w_req_addr = 11'd8; w_req_bm = 4'hF; w_req_dat = 32'h5A5A_5A5A;
    @(negedge clk);
    w_req_valid = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w_rsp_valid) begin
        seen = 1;
        check("wrap_rsp_err", w_rsp_err, 1'b0);
        break;
      end
    end
    check("wrap_rsp_seen", seen, 1'b1);
    check("wrap_aw_beats", wrap_aw_cnt, 1);

    repeat (5) @(negedge clk);
    check("queues_empty", exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
